// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the instruction-cache handshake and the IF/ID pipeline-register
//   signals of the fetch stage.
//
//   icache side : ihit, iload            (cache -> fetch)
//                 iREN, iaddr            (fetch -> cache)
//   control     : stall_IF, redirect, redirect_pc (pipeline -> fetch)
//   IF/ID side  : instruction, pc_out, npc_out, valid_out, halted (fetch -> IF/ID)
//
//   modport master : used by fetch_unit (drives the request and IF/ID fields)
//   modport slave  : used by the surrounding pipeline / cache model
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        ihit;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        stall_IF;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] npc_out;
    logic        valid_out;
    logic        halted;

    modport master (
        input  ihit, iload, stall_IF, redirect, redirect_pc,
        output iREN, iaddr, instruction, pc_out, npc_out, valid_out, halted
    );

    modport slave (
        output ihit, iload, stall_IF, redirect, redirect_pc,
        input  iREN, iaddr, instruction, pc_out, npc_out, valid_out, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Owns the PC, issues icache reads, and registers the
//   fetched word with its PC and PC+4 into the IF/ID register. Handles
//   downstream stall (one-entry hold buffer), branch/jump redirect (flush, with
//   a drop state for a read that is still in flight) and HALT detection.
//
// Parameters
//   PC_INIT : PC after reset (word aligned)
//
// Ports
//   CLK   : clock, rising edge
//   nRST  : asynchronous reset, active low
//   bus   : fetch_unit_if.master (icache request/response, stall/redirect
//           control, IF/ID outputs)
//   fetch_cnt, bubble_cnt : only with FETCH_PERF_CNT_EN defined; count
//           cycles in which valid_out is written 1 / written 0
//
// Configuration macro
//   FETCH_PERF_CNT_EN : adds the two performance counters above.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         nRST,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  fetch_cnt,
    output logic [31:0]  bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        HOLD      = 2'd1,
        WAIT_DROP = 2'd2,
        HALT      = 2'd3
    } state_t;

    // Opcode 6'h3F marks the HALT instruction.
    function automatic logic is_halt(input logic [31:0] word);
        return (word[31:26] == 6'h3F);
    endfunction

    state_t      state_r,    state_s;
    logic [31:0] pc_r,       pc_s;
    logic [31:0] req_pc_r,   req_pc_s;
    logic [31:0] hold_buf_r, hold_buf_s;
    logic [31:0] hold_pc_r,  hold_pc_s;
    logic [31:0] instr_r,    instr_s;
    logic [31:0] pc_out_r,   pc_out_s;
    logic [31:0] npc_out_r,  npc_out_s;
    logic        valid_r,    valid_s;
    logic        halted_r,   halted_s;
    logic        valid_wr_s;
    logic [31:0] redirect_pc_s;

    assign redirect_pc_s = {bus.redirect_pc[31:2], 2'b00};

    // Next-state and next-output computation; priority redirect > stall > ihit.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        req_pc_s   = req_pc_r;
        hold_buf_s = hold_buf_r;
        hold_pc_s  = hold_pc_r;
        instr_s    = instr_r;
        pc_out_s   = pc_out_r;
        npc_out_s  = npc_out_r;
        valid_s    = valid_r;
        halted_s   = halted_r;
        valid_wr_s = 1'b0;

        case (state_r)
            FETCH: begin
                if (bus.redirect) begin
                    pc_s       = redirect_pc_s;
                    valid_s    = 1'b0;
                    valid_wr_s = 1'b1;
                    if (bus.ihit) begin
                        state_s = FETCH;
                    end else begin
                        // The read for pc is still outstanding; its data must
                        // be swallowed before a new address is issued.
                        req_pc_s = pc_r;
                        state_s  = WAIT_DROP;
                    end
                end else if (bus.stall_IF) begin
                    if (bus.ihit) begin
                        hold_buf_s = bus.iload;
                        hold_pc_s  = pc_r;
                        pc_s       = pc_r + 32'd4;
                        state_s    = HOLD;
                    end else begin
                        state_s = FETCH;
                    end
                end else if (bus.ihit) begin
                    instr_s    = bus.iload;
                    pc_out_s   = pc_r;
                    npc_out_s  = pc_r + 32'd4;
                    valid_s    = 1'b1;
                    valid_wr_s = 1'b1;
                    pc_s       = pc_r + 32'd4;
                    if (is_halt(bus.iload)) begin
                        halted_s = 1'b1;
                        state_s  = HALT;
                    end else begin
                        state_s = FETCH;
                    end
                end else begin
                    valid_s    = 1'b0;
                    valid_wr_s = 1'b1;
                end
            end

            HOLD: begin
                if (bus.redirect) begin
                    pc_s       = redirect_pc_s;
                    valid_s    = 1'b0;
                    valid_wr_s = 1'b1;
                    state_s    = FETCH;
                end else if (!bus.stall_IF) begin
                    instr_s    = hold_buf_r;
                    pc_out_s   = hold_pc_r;
                    npc_out_s  = hold_pc_r + 32'd4;
                    valid_s    = 1'b1;
                    valid_wr_s = 1'b1;
                    if (is_halt(hold_buf_r)) begin
                        halted_s = 1'b1;
                        state_s  = HALT;
                    end else begin
                        state_s = FETCH;
                    end
                end else begin
                    state_s = HOLD;
                end
            end

            WAIT_DROP: begin
                if (bus.redirect) begin
                    pc_s       = redirect_pc_s;
                    valid_s    = 1'b0;
                    valid_wr_s = 1'b1;
                end else begin
                    pc_s = pc_r;
                end
                if (bus.ihit) begin
                    state_s = FETCH;
                end else begin
                    state_s = WAIT_DROP;
                end
            end

            HALT: begin
                if (bus.redirect) begin
                    // HALT was fetched on a wrong path: squash it.
                    pc_s       = redirect_pc_s;
                    valid_s    = 1'b0;
                    valid_wr_s = 1'b1;
                    halted_s   = 1'b0;
                    state_s    = FETCH;
                end else begin
                    state_s = HALT;
                end
            end

            default: begin
                state_s = FETCH;
            end
        endcase
    end

    // State, PC and IF/ID register bank.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r    <= FETCH;
            pc_r       <= PC_INIT;
            req_pc_r   <= PC_INIT;
            hold_buf_r <= 32'h0000_0000;
            hold_pc_r  <= 32'h0000_0000;
            instr_r    <= 32'h0000_0000;
            pc_out_r   <= 32'h0000_0000;
            npc_out_r  <= 32'h0000_0000;
            valid_r    <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            req_pc_r   <= req_pc_s;
            hold_buf_r <= hold_buf_s;
            hold_pc_r  <= hold_pc_s;
            instr_r    <= instr_s;
            pc_out_r   <= pc_out_s;
            npc_out_r  <= npc_out_s;
            valid_r    <= valid_s;
            halted_r   <= halted_s;
        end
    end

    // Request decode: only FETCH and WAIT_DROP talk to the cache; WAIT_DROP
    // keeps presenting the address of the read being drained.
    always_comb begin
        bus.iREN  = (state_r == FETCH) || (state_r == WAIT_DROP);
        if (state_r == WAIT_DROP) begin
            bus.iaddr = req_pc_r;
        end else begin
            bus.iaddr = pc_r;
        end
    end

    assign bus.instruction = instr_r;
    assign bus.pc_out      = pc_out_r;
    assign bus.npc_out     = npc_out_r;
    assign bus.valid_out   = valid_r;
    assign bus.halted      = halted_r;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] bubble_cnt_r;

    // Count writes of valid_out: 1 -> fetch, 0 -> bubble; both wrap.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt_r  <= 32'd0;
            bubble_cnt_r <= 32'd0;
        end else if (valid_wr_s) begin
            if (valid_s) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end else begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end
        end else begin
            fetch_cnt_r  <= fetch_cnt_r;
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign fetch_cnt  = fetch_cnt_r;
    assign bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A transaction-level model (PC, queue of
//   held words, pending-drop flag) predicts the IF/ID outputs and the cache
//   request; a compare process checks them every falling edge, and literal
//   expectations after each directed step pin the model.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic CLK;
    logic nRST;

    fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] w;
        logic [31:0] p;
    } ent_t;

    ent_t        held[$];
    logic [31:0] m_pc, m_drop_addr, m_instr, m_pc_out, m_npc;
    logic        m_drop, m_valid, m_halted;
    int unsigned m_fetch, m_bubble;

    function automatic void m_reset();
        held.delete();
        m_pc = 32'h0; m_drop = 1'b0; m_drop_addr = 32'h0;
        m_instr = 32'h0; m_pc_out = 32'h0; m_npc = 32'h0;
        m_valid = 1'b0; m_halted = 1'b0;
        m_fetch = 0; m_bubble = 0;
    endfunction

    function automatic void m_present(input ent_t e);
        m_instr = e.w; m_pc_out = e.p; m_npc = e.p + 32'd4; m_valid = 1'b1;
        m_fetch++;
        if (e.w[31:26] == 6'h3F) m_halted = 1'b1;
    endfunction

    function automatic void m_flush(input logic [31:0] tgt);
        m_pc = {tgt[31:2], 2'b00}; m_valid = 1'b0; m_bubble++;
    endfunction

    function automatic void m_step();
        ent_t e;
        if (m_halted) begin
            if (bus.redirect) begin m_flush(bus.redirect_pc); m_halted = 1'b0; end
        end else if (held.size() != 0) begin
            if (bus.redirect) begin held.delete(); m_flush(bus.redirect_pc); end
            else if (!bus.stall_IF) m_present(held.pop_front());
        end else if (m_drop) begin
            if (bus.redirect) m_flush(bus.redirect_pc);
            if (bus.ihit) m_drop = 1'b0;
        end else begin
            e.w = bus.iload; e.p = m_pc;
            if (bus.redirect) begin
                if (!bus.ihit) begin m_drop = 1'b1; m_drop_addr = m_pc; end
                m_flush(bus.redirect_pc);
            end else if (bus.ihit && bus.stall_IF) begin
                held.push_back(e); m_pc = m_pc + 32'd4;
            end else if (bus.ihit) begin
                m_present(e); m_pc = m_pc + 32'd4;
            end else if (!bus.stall_IF) begin
                m_valid = 1'b0; m_bubble++;
            end
        end
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge CLK or negedge nRST);
            if (!nRST) m_reset();
            else m_step();
        end
    end

    // ---------------- compare process ----------------
    logic chk_en = 1'b0;
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                chk("m.iREN", {31'd0, bus.iREN}, {31'd0, !m_halted && (held.size() == 0)});
                if (!m_halted && (held.size() == 0))
                    chk("m.iaddr", bus.iaddr, m_drop ? m_drop_addr : m_pc);
                chk("m.valid_out", {31'd0, bus.valid_out}, {31'd0, m_valid});
                chk("m.halted", {31'd0, bus.halted}, {31'd0, m_halted});
                chk("m.instruction", bus.instruction, m_instr);
                chk("m.pc_out", bus.pc_out, m_pc_out);
                chk("m.npc_out", bus.npc_out, m_npc);
`ifdef FETCH_PERF_CNT_EN
                chk("m.fetch_cnt", fetch_cnt, m_fetch);
                chk("m.bubble_cnt", bubble_cnt, m_bubble);
`endif
            end
        end
    end

    // Hard time bound.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000");
        $fatal(1, "timeout");
    end

    // One clock step: drive inputs, take the edge, settle 2 time units.
    task automatic cyc(input logic ihit, input logic [31:0] iload, input logic stall,
                       input logic redir, input logic [31:0] rpc);
        bus.ihit = ihit; bus.iload = iload; bus.stall_IF = stall;
        bus.redirect = redir; bus.redirect_pc = rpc;
        @(posedge CLK);
        #2;
    endtask

    task automatic out(input string n, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        chk({n, ".valid"}, {31'd0, bus.valid_out}, {31'd0, v});
        chk({n, ".pc_out"}, bus.pc_out, pc);
        chk({n, ".npc_out"}, bus.npc_out, pc + 32'd4);
        chk({n, ".instr"}, bus.instruction, ins);
    endtask

    initial begin
        nRST = 1'b0;
        bus.ihit = 1'b0; bus.iload = 32'h0; bus.stall_IF = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
        repeat (2) @(posedge CLK);
        #2;
        chk_en = 1'b1;
        // Reset state
        chk("rst.iREN", {31'd0, bus.iREN}, 32'd1);
        chk("rst.iaddr", bus.iaddr, 32'h0);
        chk("rst.valid", {31'd0, bus.valid_out}, 32'd0);
        chk("rst.halted", {31'd0, bus.halted}, 32'd0);
        chk("rst.instr", bus.instruction, 32'h0);
        chk("rst.pc_out", bus.pc_out, 32'h0);
        nRST = 1'b1;

        // T1: back-to-back hits
        cyc(1'b1, 32'h2001_0005, 1'b0, 1'b0, 32'h0);
        out("t1a", 1'b1, 32'h0, 32'h2001_0005);
        cyc(1'b1, 32'h2002_0007, 1'b0, 1'b0, 32'h0);
        out("t1b", 1'b1, 32'h4, 32'h2002_0007);

        // T2: three misses at pc 8
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk("t2.valid", {31'd0, bus.valid_out}, 32'd0);
            chk("t2.iaddr", bus.iaddr, 32'h8);
        end
        cyc(1'b1, 32'h2003_0009, 1'b0, 1'b0, 32'h0);
        out("t2.deliver", 1'b1, 32'h8, 32'h2003_0009);

        // T3: hit while stalled at pc C, stall held 2 cycles
        cyc(1'b1, 32'h2004_000B, 1'b1, 1'b0, 32'h0);
        chk("t3.iREN0", {31'd0, bus.iREN}, 32'd0);
        out("t3.frozen", 1'b1, 32'h8, 32'h2003_0009);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("t3.iREN1", {31'd0, bus.iREN}, 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        out("t3.release", 1'b1, 32'hC, 32'h2004_000B);
        chk("t3.iaddr", bus.iaddr, 32'h10);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t3.once", {31'd0, bus.valid_out}, 32'd0);

        // T4: redirect with read in flight
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h107);
        chk("t4.valid", {31'd0, bus.valid_out}, 32'd0);
        chk("t4.iaddr", bus.iaddr, 32'h10);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t4.iaddr_hold", bus.iaddr, 32'h10);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        chk("t4.dropped", {31'd0, bus.valid_out}, 32'd0);
        chk("t4.iaddr_new", bus.iaddr, 32'h104);
        cyc(1'b1, 32'h2005_0001, 1'b0, 1'b0, 32'h0);
        out("t4.fetch", 1'b1, 32'h104, 32'h2005_0001);
`ifdef FETCH_PERF_CNT_EN
        chk("t4.fetch_cnt", fetch_cnt, 32'd5);
        chk("t4.bubble_cnt", bubble_cnt, 32'd5);
`endif

        // Stall without hit keeps outputs
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        out("stall_miss", 1'b1, 32'h104, 32'h2005_0001);

        // T6: wrap at top of address space
        cyc(1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("t6.valid", {31'd0, bus.valid_out}, 32'd0);
        chk("t6.iaddr", bus.iaddr, 32'hFFFF_FFFC);
        cyc(1'b1, 32'h2006_0002, 1'b0, 1'b0, 32'h0);
        chk("t6.npc_wrap", bus.npc_out, 32'h0);
        chk("t6.iaddr_wrap", bus.iaddr, 32'h0);
        cyc(1'b1, 32'h2007_0003, 1'b0, 1'b0, 32'h0);
        out("t6.after", 1'b1, 32'h0, 32'h2007_0003);

        // T5: HALT word at pc 4
        cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        out("t5.halt", 1'b1, 32'h4, 32'hFFFF_FFFF);
        chk("t5.halted", {31'd0, bus.halted}, 32'd1);
        chk("t5.iREN", {31'd0, bus.iREN}, 32'd0);
        cyc(1'b1, 32'h2008_0000, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 32'h2008_0000, 1'b0, 1'b0, 32'h0);
        out("t5.frozen", 1'b1, 32'h4, 32'hFFFF_FFFF);
        // Wrong-path squash
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h202);
        chk("t5.unhalt", {31'd0, bus.halted}, 32'd0);
        chk("t5.iaddr", bus.iaddr, 32'h200);
        cyc(1'b1, 32'h2009_0000, 1'b0, 1'b0, 32'h0);
        out("t5.resume", 1'b1, 32'h200, 32'h2009_0000);

        // HALT word arriving through the hold buffer
        cyc(1'b1, 32'hFC00_0000, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        out("hold_halt", 1'b1, 32'h204, 32'hFC00_0000);
        chk("hold_halt.halted", {31'd0, bus.halted}, 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h300);

        // Redirect drops a held word
        cyc(1'b1, 32'h200A_0000, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h400);
        chk("hold_redir.valid", {31'd0, bus.valid_out}, 32'd0);
        chk("hold_redir.iaddr", bus.iaddr, 32'h400);
        cyc(1'b1, 32'h200B_0000, 1'b0, 1'b0, 32'h0);
        out("hold_redir.fetch", 1'b1, 32'h400, 32'h200B_0000);

        // Reset in the middle of a drop
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h500);
        nRST = 1'b0;
        #1;
        chk("midrst.iaddr", bus.iaddr, 32'h0);
        chk("midrst.valid", {31'd0, bus.valid_out}, 32'd0);
        chk("midrst.iREN", {31'd0, bus.iREN}, 32'd1);
        cyc(1'b1, 32'h200C_0000, 1'b0, 1'b0, 32'h0);
        nRST = 1'b1;
        cyc(1'b1, 32'h200D_0000, 1'b0, 1'b0, 32'h0);
        out("midrst.fetch", 1'b1, 32'h0, 32'h200D_0000);

        @(negedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
